bist_response_analyzer: RTL and testbench

- Response-side half of the on-chip BIST loop; the LFSR pattern generators drive the stimulus side.
- Compacts a fixed-length stream of circuit-under-test responses into a polynomial MISR signature.
- Counts accepted patterns, compares the final signature against a golden value, and reports busy/done/pass to the test controller.
- Sits between the CUT output register (e.g. the 17-bit adder result) and the top-level BIST status outputs.

---
 rtl/bist_pkg.sv | 36 +++
 rtl/bist_response_analyzer_misr.sv | 30 +++
 rtl/bist_response_analyzer.sv | 117 +++++++++++
 tb/tb_bist_response_analyzer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared BIST constants, FSM state type and the response fold helper.
// Used by the response analyzer and its MISR core; the pattern-side
// generators import the same defaults so both halves agree on widths.
package bist_pkg;

    localparam int unsigned DEF_DATA_W = 17;
    localparam int unsigned DEF_SIG_W  = 10;
    localparam logic [DEF_SIG_W-1:0] DEF_POLY = 10'h009;  // x^10 + x^3 + 1

    // Widest response word the fold helper accepts (zero-padded up to this).
    localparam int unsigned FOLD_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        COMPARE,
        DONE
    } bist_state_e;

    // One output bit of the fold: zero-padding the word to a multiple of
    // sig_w and XORing all sig_w-bit chunks places data bit i on output
    // bit (i mod sig_w).
    function automatic logic fold_bit(input logic [FOLD_MAX_W-1:0] data,
                                      input int unsigned           sig_w,
                                      input int unsigned           bit_idx);
        logic acc;
        acc = 1'b0;
        for (int unsigned i = 0; i < FOLD_MAX_W; i++) begin
            if ((i % sig_w) == bit_idx) begin
                acc = acc ^ data[i];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/bist_response_analyzer_misr.sv
// Combinational MISR next-state: shift left, polynomial feedback from the
// MSB, then XOR in the folded response word.
// Ports: sig_in (current signature), data_in (response word),
//        poly (feedback taps), sig_next (next signature).
module misr_core
    import bist_pkg::*;
#(
    parameter int unsigned SIG_W  = DEF_SIG_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [SIG_W-1:0]  sig_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [SIG_W-1:0]  poly,
    output logic [SIG_W-1:0]  sig_next
);

    logic [FOLD_MAX_W-1:0] data_ext;
    logic [SIG_W-1:0]      folded;
    logic [SIG_W-1:0]      shifted;

    assign data_ext = FOLD_MAX_W'(data_in);

    for (genvar g = 0; g < SIG_W; g++) begin : g_fold
        assign folded[g] = fold_bit(data_ext, SIG_W, g);
    end

    assign shifted  = {sig_in[SIG_W-2:0], 1'b0};
    assign sig_next = shifted ^ (sig_in[SIG_W-1] ? poly : '0) ^ folded;

endmodule

// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: compacts NUM_PATTERNS CUT responses into a MISR
// signature, then compares it against a golden value sampled on start.
// Ports: clk, rst_n (async active-low), start, abort, resp_valid,
//        resp_data, golden_sig (inputs); busy, done, pass, signature,
//        pattern_count (registered outputs).
module bist_response_analyzer
    import bist_pkg::*;
#(
    parameter int unsigned      DATA_W       = DEF_DATA_W,
    parameter int unsigned      SIG_W        = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY         = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED         = '0,
    parameter int unsigned      NUM_PATTERNS = 256,
    parameter int unsigned      CNT_W        = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_data,
    input  logic [SIG_W-1:0]  golden_sig,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  pattern_count
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PATTERNS - 1);

    bist_state_e      state, state_n;
    logic [SIG_W-1:0] golden_q, golden_n;
    logic [SIG_W-1:0] sig_n, misr_next;
    logic [CNT_W-1:0] cnt_n;
    logic             busy_n, done_n, pass_n;

    misr_core #(
        .SIG_W  (SIG_W),
        .DATA_W (DATA_W)
    ) u_misr (
        .sig_in   (signature),
        .data_in  (resp_data),
        .poly     (POLY),
        .sig_next (misr_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            signature     <= '0;
            pattern_count <= '0;
            golden_q      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else begin
            state         <= state_n;
            signature     <= sig_n;
            pattern_count <= cnt_n;
            golden_q      <= golden_n;
            busy          <= busy_n;
            done          <= done_n;
            pass          <= pass_n;
        end
    end

    always_comb begin
        state_n  = state;
        sig_n    = signature;
        cnt_n    = pattern_count;
        golden_n = golden_q;
        busy_n   = busy;
        done_n   = done;
        pass_n   = pass;

        // Abort wins over everything, including a same-edge start or response;
        // signature and count are left untouched for debug.
        if (abort) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b0;
            pass_n  = 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_n  = RUN;
                        sig_n    = SEED;
                        cnt_n    = '0;
                        golden_n = golden_sig;
                        busy_n   = 1'b1;
                        done_n   = 1'b0;
                        pass_n   = 1'b0;
                    end
                end
                RUN: begin
                    if (resp_valid) begin
                        sig_n = misr_next;
                        cnt_n = pattern_count + CNT_W'(1);
                        if (pattern_count == LAST_IDX) begin
                            state_n = COMPARE;
                        end
                    end
                end
                COMPARE: begin
                    pass_n  = (signature == golden_q);
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = DONE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_response_analyzer.sv
module tb_bist_response_analyzer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        resp_valid;
    logic [16:0] resp_data;
    logic [9:0]  golden_sig;

    logic        busy4, done4, pass4;
    logic [9:0]  sig4;
    logic [8:0]  cnt4;
    logic        busy1, done1, pass1;
    logic [9:0]  sig1;
    logic [8:0]  cnt1;

    int checks = 0;
    int errors = 0;

    bist_response_analyzer #(
        .NUM_PATTERNS (4),
        .SEED         (10'h000)
    ) u_dut4 (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .golden_sig    (golden_sig),
        .busy          (busy4),
        .done          (done4),
        .pass          (pass4),
        .signature     (sig4),
        .pattern_count (cnt4)
    );

    bist_response_analyzer #(
        .NUM_PATTERNS (1),
        .SEED         (10'h200)
    ) u_dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .golden_sig    (golden_sig),
        .busy          (busy1),
        .done          (done1),
        .pass          (pass1),
        .signature     (sig1),
        .pattern_count (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference compaction step from the arithmetic definition:
    // double mod 2^10, feedback if the old MSB was set, then add (XOR) the
    // low 10 bits and the high 7 bits of the response.
    function automatic logic [9:0] model_step(input logic [9:0] s, input logic [16:0] d);
        int unsigned si, di, nxt;
        si  = s;
        di  = d;
        nxt = (si * 2) % 1024;
        if (si >= 512) nxt = nxt ^ 9;
        nxt = nxt ^ (di % 1024) ^ (di / 1024);
        return 10'(nxt);
    endfunction

    initial begin
        logic        v_pat [10];
        logic [16:0] stream [4];
        logic [9:0]  seq [4];
        logic [16:0] rdata [4];
        logic [9:0]  exp_sig, final_sig, gold;
        int          acc, gaps, abort_at;
        logic        do_abort, aborted;

        v_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        stream = '{17'h00001, 17'h00400, 17'h00000, 17'h00000};
        seq    = '{10'h001, 10'h003, 10'h006, 10'h00C};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; resp_valid = 1'b0;
        resp_data = '0; golden_sig = '0;
        tick(); tick();
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_done", 32'(done4), 32'd0);
        chk("rst_pass", 32'(pass4), 32'd0);
        chk("rst_sig", 32'(sig4), 32'd0);
        chk("rst_cnt", 32'(cnt4), 32'd0);
        rst_n = 1'b1;
        tick();

        // Golden match run
        golden_sig = 10'h00C; start = 1'b1; tick(); start = 1'b0;
        chk("a_busy", 32'(busy4), 32'd1);
        chk("a_cnt0", 32'(cnt4), 32'd0);
        chk("a_sig0", 32'(sig4), 32'd0);
        for (int i = 0; i < 4; i++) begin
            resp_valid = 1'b1; resp_data = stream[i]; tick();
            chk("a_sig", 32'(sig4), 32'(seq[i]));
            chk("a_cnt", 32'(cnt4), 32'(i + 1));
        end
        resp_valid = 1'b0; resp_data = 17'h1FFFF;
        chk("a_done_early", 32'(done4), 32'd0);
        chk("a_busy_cmp", 32'(busy4), 32'd1);
        tick();
        chk("a_done", 32'(done4), 32'd1);
        chk("a_pass", 32'(pass4), 32'd1);
        chk("a_busy_fall", 32'(busy4), 32'd0);
        chk("a_sig_final", 32'(sig4), 32'h00C);
        tick();
        chk("a_done_hold", 32'(done4), 32'd1);
        chk("a_pass_hold", 32'(pass4), 32'd1);
        chk("a_cnt_hold", 32'(cnt4), 32'd4);

        // Restart from DONE, mismatching golden, gapped stream, start in RUN
        golden_sig = 10'h00D; start = 1'b1; tick(); start = 1'b0;
        chk("b_done_clr", 32'(done4), 32'd0);
        chk("b_pass_clr", 32'(pass4), 32'd0);
        chk("b_cnt_clr", 32'(cnt4), 32'd0);
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            resp_valid = v_pat[i];
            resp_data  = v_pat[i] ? stream[acc] : 17'h1FFFF;
            start      = (i == 4);
            if (i == 4) golden_sig = 10'h00C;
            tick();
            if (v_pat[i]) acc++;
            chk("b_cnt", 32'(cnt4), 32'(acc));
            if (acc > 0) chk("b_sig", 32'(sig4), 32'(seq[acc-1]));
        end
        start = 1'b0; resp_valid = 1'b0;
        tick();
        chk("b_done", 32'(done4), 32'd1);
        chk("b_pass", 32'(pass4), 32'd0);
        chk("b_sig_final", 32'(sig4), 32'h00C);

        // Abort after 2 responses; response on the abort edge is dropped
        golden_sig = 10'h00C; start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            resp_valid = 1'b1; resp_data = stream[i]; tick();
        end
        resp_data = 17'h00000; abort = 1'b1; tick(); abort = 1'b0; resp_valid = 1'b0;
        chk("ab_busy", 32'(busy4), 32'd0);
        chk("ab_done", 32'(done4), 32'd0);
        chk("ab_sig", 32'(sig4), 32'h003);
        chk("ab_cnt", 32'(cnt4), 32'd2);
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        chk("sa_busy", 32'(busy4), 32'd0);
        chk("sa_sig", 32'(sig4), 32'h003);
        resp_valid = 1'b1; resp_data = 17'h00001; tick(); resp_valid = 1'b0;
        chk("idle_ignore", 32'(sig4), 32'h003);

        // Fold of an all-ones word
        start = 1'b1; tick(); start = 1'b0;
        resp_valid = 1'b1; resp_data = 17'h1FFFF; tick(); resp_valid = 1'b0;
        chk("fold_sig", 32'(sig4), 32'h380);
        abort = 1'b1; tick(); abort = 1'b0;

        // Feedback path on the single-pattern instance (SEED=0x200)
        golden_sig = 10'h009; start = 1'b1; tick(); start = 1'b0;
        chk("fb_seed", 32'(sig1), 32'h200);
        resp_valid = 1'b1; resp_data = 17'h00000; tick(); resp_valid = 1'b0;
        chk("fb_sig", 32'(sig1), 32'h009);
        chk("fb_cnt", 32'(cnt1), 32'd1);
        tick();
        chk("fb_done", 32'(done1), 32'd1);
        chk("fb_pass", 32'(pass1), 32'd1);
        abort = 1'b1; tick(); abort = 1'b0;

        // Randomized sessions against the reference model
        for (int s = 0; s < 24; s++) begin
            final_sig = 10'h000;
            for (int i = 0; i < 4; i++) begin
                rdata[i]  = 17'($urandom_range(0, 17'h1FFFF));
                final_sig = model_step(final_sig, rdata[i]);
            end
            gold     = ($urandom_range(0, 1) == 1) ? final_sig
                                                   : final_sig ^ 10'($urandom_range(1, 1023));
            do_abort = ($urandom_range(0, 4) == 0);
            abort_at = int'($urandom_range(1, 3));
            aborted  = 1'b0;
            exp_sig  = 10'h000;
            golden_sig = gold; start = 1'b1; tick(); start = 1'b0;
            chk("r_start_busy", 32'(busy4), 32'd1);
            for (int i = 0; i < 4; i++) begin
                if (!aborted) begin
                    gaps = int'($urandom_range(0, 2));
                    for (int g = 0; g < gaps; g++) begin
                        resp_valid = 1'b0; resp_data = 17'($urandom); tick();
                    end
                    chk("r_gap_sig", 32'(sig4), 32'(exp_sig));
                    resp_valid = 1'b1; resp_data = rdata[i]; tick(); resp_valid = 1'b0;
                    exp_sig = model_step(exp_sig, rdata[i]);
                    chk("r_sig", 32'(sig4), 32'(exp_sig));
                    chk("r_cnt", 32'(cnt4), 32'(i + 1));
                    if (do_abort && (i + 1 == abort_at)) begin
                        abort = 1'b1; tick(); abort = 1'b0;
                        chk("r_ab_busy", 32'(busy4), 32'd0);
                        chk("r_ab_sig", 32'(sig4), 32'(exp_sig));
                        aborted = 1'b1;
                    end
                end
            end
            if (!aborted) begin
                tick();
                chk("r_done", 32'(done4), 32'd1);
                chk("r_pass", 32'(pass4), 32'(gold == final_sig));
                chk("r_busy", 32'(busy4), 32'd0);
            end
        end

        // Asynchronous reset in the middle of a session
        golden_sig = 10'h00C; start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            resp_valid = 1'b1; resp_data = stream[i]; tick();
        end
        resp_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy4), 32'd0);
        chk("ar_sig", 32'(sig4), 32'd0);
        chk("ar_cnt", 32'(cnt4), 32'd0);
        chk("ar_done", 32'(done4), 32'd0);
        tick();
        rst_n = 1'b1;
        resp_valid = 1'b1; resp_data = 17'h1FFFF; tick(); tick(); resp_valid = 1'b0;
        chk("ar_post_sig", 32'(sig4), 32'd0);
        chk("ar_post_cnt", 32'(cnt4), 32'd0);
        chk("ar_post_busy", 32'(busy4), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
